alu_execute: RTL and testbench

Execute stage that sits directly downstream of the opcode controller. It consumes the registered opcode, operand and unit-select bundle each cycle and computes the 8-bit result and flags in a two-edge pipeline. Results are pushed into a small result FIFO that drains to the register-file/display side through a valid/ready handshake. Bubbles (idle opcode) produce no entry.

---
 rtl/alu_pkg.sv | 37 +++
 rtl/result_fifo.sv | 51 +++++
 rtl/alu_execute.sv | 134 +++++++++++++
 tb/tb_alu_execute.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// alu_pkg: shared opcode/select encodings, flag bit positions and the result FIFO entry type
// No ports; imported by alu_execute and its result FIFO.
package alu_pkg;

    localparam int RESULT_W = 8;

    localparam logic [3:0] TRANSFER  = 4'h0;
    localparam logic [3:0] INC       = 4'h1;
    localparam logic [3:0] ADD       = 4'h2;
    localparam logic [3:0] SUB       = 4'h3;
    localparam logic [3:0] DEC       = 4'h4;
    localparam logic [3:0] ONES_COMP = 4'h5;
    localparam logic [3:0] A_AND_B   = 4'h6;
    localparam logic [3:0] A_NAND_B  = 4'h7;
    localparam logic [3:0] A_OR_B    = 4'h8;
    localparam logic [3:0] A_NOR_B   = 4'h9;
    localparam logic [3:0] A_XOR_B   = 4'hA;
    localparam logic [3:0] A_XNOR_B  = 4'hB;
    localparam logic [3:0] A_GT_B    = 4'hC;
    localparam logic [3:0] A_LT_B    = 4'hD;
    localparam logic [3:0] A_EQ_B    = 4'hE;
    localparam logic [3:0] OP_IDLE   = 4'hF;

    localparam logic [2:0] SEL_IDLE = 3'b100;

    localparam int FLAG_C = 3;
    localparam int FLAG_V = 2;
    localparam int FLAG_N = 1;
    localparam int FLAG_Z = 0;

    typedef struct packed {
        logic [3:0]          op;
        logic [3:0]          flags;
        logic [RESULT_W-1:0] result;
    } result_entry_t;

endpackage

// File: rtl/result_fifo.sv
// result_fifo: synchronous FIFO with async reset; pointers carry an extra wrap bit
// Ports: Clk, Reset (async, active-high); push/wdata write request; pop read request;
//        rdata head entry; full/empty status; accepted = the push was taken this cycle.
module result_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 16
) (
    input  logic         Clk,
    input  logic         Reset,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] wdata,
    output logic [W-1:0] rdata,
    output logic         full,
    output logic         empty,
    output logic         accepted
);
    localparam int AW = $clog2(DEPTH);

    logic [AW:0]  wptr_q, wptr_d, rptr_q, rptr_d;
    logic [W-1:0] mem_q [DEPTH];
    logic [W-1:0] mem_d [DEPTH];
    logic         do_pop;

    assign empty    = wptr_q == rptr_q;
    assign full     = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
    assign do_pop   = pop && !empty;
    // A pop frees the head slot in the same cycle, so a full FIFO can still take a push.
    assign accepted = push && (!full || do_pop);
    assign rdata    = mem_q[rptr_q[AW-1:0]];

    always_comb begin
        mem_d = mem_q;
        if (accepted) mem_d[wptr_q[AW-1:0]] = wdata;
        wptr_d = accepted ? wptr_q + 1'b1 : wptr_q;
        rptr_d = do_pop ? rptr_q + 1'b1 : rptr_q;
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            wptr_q <= '0;
            rptr_q <= '0;
            mem_q  <= '{default: '0};
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
            mem_q  <= mem_d;
        end
    end

endmodule

// File: rtl/alu_execute.sv
// alu_execute: two-edge ALU execute stage feeding a valid/ready result FIFO
// Ports: Clk, Reset (async, active-high); Op/DataA/DataB/Sel from the controller;
//        Out_Ready downstream accept; Clear_Overrun clears the sticky drop flag;
//        Out_Valid/Result/ResultOp/Flags FIFO head; Overrun sticky drop; OpCount accepted pushes.
module alu_execute
    import alu_pkg::*;
#(
    parameter int WIDTH = RESULT_W,
    parameter int DEPTH = 4,
    parameter int CNT_W = 16
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic [3:0]       Op,
    input  logic [WIDTH-1:0] DataA,
    input  logic [WIDTH-1:0] DataB,
    input  logic [2:0]       Sel,
    input  logic             Out_Ready,
    input  logic             Clear_Overrun,
    output logic             Out_Valid,
    output logic [WIDTH-1:0] Result,
    output logic [3:0]       ResultOp,
    output logic [3:0]       Flags,
    output logic             Overrun,
    output logic [CNT_W-1:0] OpCount
);
    localparam int M = WIDTH - 1;

    logic             s1_valid_q, s1_valid_d;
    logic [3:0]       s1_op_q, s1_op_d;
    logic [WIDTH-1:0] s1_a_q, s1_a_d, s1_b_q, s1_b_d;
    logic             overrun_q, overrun_d;
    logic [CNT_W-1:0] count_q, count_d;

    logic [WIDTH-1:0] op2, r;
    logic [WIDTH:0]   sum, diff;
    logic             c, v;
    logic [3:0]       flags;
    result_entry_t    wr_entry, head;
    logic             pop, full, empty, accepted;

    always_comb begin
        s1_valid_d = (Op != OP_IDLE) && (Sel != SEL_IDLE);
        s1_op_d    = Op;
        s1_a_d     = DataA;
        s1_b_d     = DataB;
    end

    // Inc/Dec reuse the add/sub paths with a constant 1 as the second operand.
    always_comb begin
        op2  = (s1_op_q == INC || s1_op_q == DEC) ? WIDTH'(1) : s1_b_q;
        sum  = {1'b0, s1_a_q} + {1'b0, op2};
        diff = {1'b0, s1_a_q} - {1'b0, op2};
        r = '0;
        c = 1'b0;
        v = 1'b0;
        case (s1_op_q)
            TRANSFER:   r = s1_a_q;
            INC, ADD: begin
                r = sum[M:0];
                c = sum[WIDTH];
                v = (s1_a_q[M] == op2[M]) && (r[M] != s1_a_q[M]);
            end
            SUB, DEC: begin
                r = diff[M:0];
                c = diff[WIDTH];
                v = (s1_a_q[M] != op2[M]) && (r[M] != s1_a_q[M]);
            end
            ONES_COMP:  r = ~s1_a_q;
            A_AND_B:    r = s1_a_q & s1_b_q;
            A_NAND_B:   r = ~(s1_a_q & s1_b_q);
            A_OR_B:     r = s1_a_q | s1_b_q;
            A_NOR_B:    r = ~(s1_a_q | s1_b_q);
            A_XOR_B:    r = s1_a_q ^ s1_b_q;
            A_XNOR_B:   r = ~(s1_a_q ^ s1_b_q);
            A_GT_B:     r = WIDTH'(s1_a_q > s1_b_q);
            A_LT_B:     r = WIDTH'(s1_a_q < s1_b_q);
            A_EQ_B:     r = WIDTH'(s1_a_q == s1_b_q);
            default:    r = '0;
        endcase
        flags         = '0;
        flags[FLAG_C] = c;
        flags[FLAG_V] = v;
        flags[FLAG_N] = r[M];
        flags[FLAG_Z] = r == '0;
        wr_entry      = '{op: s1_op_q, flags: flags, result: r};
    end

    assign pop = Out_Valid && Out_Ready;

    result_fifo #(.DEPTH(DEPTH), .W($bits(result_entry_t))) u_fifo (
        .Clk      (Clk),
        .Reset    (Reset),
        .push     (s1_valid_q),
        .pop      (pop),
        .wdata    (wr_entry),
        .rdata    (head),
        .full     (full),
        .empty    (empty),
        .accepted (accepted)
    );

    // A drop in the same cycle as Clear_Overrun keeps the flag set.
    always_comb begin
        overrun_d = (s1_valid_q && !accepted) ? 1'b1 : (Clear_Overrun ? 1'b0 : overrun_q);
        count_d   = accepted ? count_q + 1'b1 : count_q;
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            s1_valid_q <= 1'b0;
            s1_op_q    <= OP_IDLE;
            s1_a_q     <= '0;
            s1_b_q     <= '0;
            overrun_q  <= 1'b0;
            count_q    <= '0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_op_q    <= s1_op_d;
            s1_a_q     <= s1_a_d;
            s1_b_q     <= s1_b_d;
            overrun_q  <= overrun_d;
            count_q    <= count_d;
        end
    end

    assign Out_Valid = !empty;
    assign Result    = empty ? '0 : head.result;
    assign Flags     = empty ? '0 : head.flags;
    assign ResultOp  = empty ? OP_IDLE : head.op;
    assign Overrun   = overrun_q;
    assign OpCount   = count_q;

endmodule

// File: tb/tb_alu_execute.sv
// tb_alu_execute: directed scoreboard bench for alu_execute
module tb_alu_execute;
    localparam int DEPTH = 4;

    logic        Clk = 1'b0;
    logic        Reset = 1'b1;
    logic [3:0]  Op = 4'hF;
    logic [7:0]  DataA = '0, DataB = '0;
    logic [2:0]  Sel = 3'b100;
    logic        Out_Ready = 1'b0, Clear_Overrun = 1'b0;
    logic        Out_Valid, Overrun;
    logic [7:0]  Result;
    logic [3:0]  ResultOp, Flags;
    logic [15:0] OpCount;

    int checks = 0;
    int errors = 0;

    logic [15:0] exp_q[$];
    logic        s1_v = 1'b0;
    logic [15:0] s1_e = '0;
    logic [15:0] cnt = '0;
    logic        ovr = 1'b0;

    alu_execute #(.WIDTH(8), .DEPTH(DEPTH), .CNT_W(16)) dut (
        .Clk(Clk), .Reset(Reset), .Op(Op), .DataA(DataA), .DataB(DataB), .Sel(Sel),
        .Out_Ready(Out_Ready), .Clear_Overrun(Clear_Overrun), .Out_Valid(Out_Valid),
        .Result(Result), .ResultOp(ResultOp), .Flags(Flags), .Overrun(Overrun), .OpCount(OpCount)
    );

    always #5 Clk = ~Clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] model(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
        logic [8:0] s;
        logic [7:0] r;
        logic c, v;
        int sa, sb, sr;
        c = 1'b0;
        v = 1'b0;
        s = '0;
        sa = $signed(a);
        sb = $signed(b);
        case (op)
            4'h0: r = a;
            4'h1: begin s = {1'b0, a} + 9'd1; r = s[7:0]; c = s[8]; sr = sa + 1; v = sr > 127; end
            4'h2: begin s = {1'b0, a} + {1'b0, b}; r = s[7:0]; c = s[8]; sr = sa + sb; v = sr > 127 || sr < -128; end
            4'h3: begin r = a - b; c = a < b; sr = sa - sb; v = sr > 127 || sr < -128; end
            4'h4: begin r = a - 8'd1; c = a == 8'd0; sr = sa - 1; v = sr < -128; end
            4'h5: r = ~a;
            4'h6: r = a & b;
            4'h7: r = ~(a & b);
            4'h8: r = a | b;
            4'h9: r = ~(a | b);
            4'hA: r = a ^ b;
            4'hB: r = ~(a ^ b);
            4'hC: r = {7'b0, a > b};
            4'hD: r = {7'b0, a < b};
            4'hE: r = {7'b0, a == b};
            default: r = 8'h00;
        endcase
        return {op, c, v, r[7], r == 8'h00, r};
    endfunction

    // Drive one cycle, check the DUT against the scoreboard, then advance the model across the edge.
    task automatic step(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b,
                        input logic [2:0] sel, input logic rdy, input logic clr);
        logic drop;
        logic [15:0] head;
        Op = op; DataA = a; DataB = b; Sel = sel; Out_Ready = rdy; Clear_Overrun = clr;
        #1;
        chk("out_valid", {31'b0, Out_Valid}, {31'b0, exp_q.size() != 0});
        chk("opcount", {16'b0, OpCount}, {16'b0, cnt});
        chk("overrun", {31'b0, Overrun}, {31'b0, ovr});
        head = exp_q.size() != 0 ? exp_q[0] : 16'hF000;
        chk("head", {16'b0, ResultOp, Flags, Result}, {16'b0, head});
        if (rdy && exp_q.size() != 0) void'(exp_q.pop_front());
        drop = 1'b0;
        if (s1_v) begin
            if (exp_q.size() < DEPTH) begin
                exp_q.push_back(s1_e);
                cnt = cnt + 16'd1;
            end else begin
                drop = 1'b1;
                ovr = 1'b1;
            end
        end
        if (clr && !drop) ovr = 1'b0;
        s1_v = (op != 4'hF) && (sel != 3'b100);
        s1_e = model(op, a, b);
        @(posedge Clk);
        #1;
    endtask

    task automatic idle(input logic rdy, input int n);
        for (int i = 0; i < n; i++) step(4'hF, 8'h00, 8'h00, 3'b100, rdy, 1'b0);
    endtask

    initial begin
        repeat (2) @(posedge Clk);
        #1;
        chk("rst_valid", {31'b0, Out_Valid}, 32'd0);
        chk("rst_resultop", {28'b0, ResultOp}, 32'hF);
        chk("rst_result", {24'b0, Result}, 32'd0);
        chk("rst_flags", {28'b0, Flags}, 32'd0);
        chk("rst_overrun", {31'b0, Overrun}, 32'd0);
        chk("rst_opcount", {16'b0, OpCount}, 32'd0);
        Reset = 1'b0;
        idle(1'b0, 10);

        step(4'h2, 8'hFF, 8'h01, 3'b000, 1'b1, 1'b0);
        step(4'h2, 8'h7F, 8'h01, 3'b000, 1'b1, 1'b0);
        chk("add_ff_result", {24'b0, Result}, 32'h00);
        chk("add_ff_flags", {28'b0, Flags}, 32'b1001);
        chk("add_ff_op", {28'b0, ResultOp}, 32'h2);
        step(4'h3, 8'h03, 8'h05, 3'b001, 1'b1, 1'b0);
        chk("add_7f_result", {24'b0, Result}, 32'h80);
        chk("add_7f_flags", {28'b0, Flags}, 32'b0110);
        step(4'h4, 8'h00, 8'h55, 3'b001, 1'b1, 1'b0);
        chk("sub_result", {24'b0, Result}, 32'hFE);
        chk("sub_flags", {28'b0, Flags}, 32'b1010);
        step(4'hC, 8'h09, 8'h03, 3'b010, 1'b1, 1'b0);
        chk("dec_result", {24'b0, Result}, 32'hFF);
        chk("dec_carry", {31'b0, Flags[3]}, 32'd1);
        step(4'hE, 8'h04, 8'h05, 3'b010, 1'b1, 1'b0);
        chk("gt_result", {24'b0, Result}, 32'h01);
        step(4'h2, 8'h11, 8'h22, 3'b100, 1'b1, 1'b0);
        chk("eq_result", {24'b0, Result}, 32'h00);
        chk("eq_flags", {28'b0, Flags}, 32'b0001);
        idle(1'b1, 4);

        for (int i = 0; i < 5; i++) step(4'h2, 8'(i), 8'(10 * i), 3'b000, 1'b0, 1'b0);
        idle(1'b0, 2);
        chk("ovf_overrun", {31'b0, Overrun}, 32'd1);
        chk("ovf_opcount", {16'b0, OpCount}, 32'd10);
        chk("ovf_head", {24'b0, Result}, 32'h00);
        step(4'hF, 8'h00, 8'h00, 3'b100, 1'b0, 1'b1);
        chk("clr_overrun", {31'b0, Overrun}, 32'd0);

        step(4'h1, 8'h7F, 8'h00, 3'b000, 1'b0, 1'b0);
        for (int i = 0; i < 10; i++)
            step(4'(i % 15), 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), 3'b011, 1'b1, 1'b0);
        chk("stream_overrun", {31'b0, Overrun}, 32'd0);
        idle(1'b1, 6);

        for (int i = 0; i < 3; i++) step(4'h8, 8'(i + 1), 8'h40, 3'b000, 1'b0, 1'b0);
        idle(1'b0, 1);
        chk("pre_rst_valid", {31'b0, Out_Valid}, 32'd1);
        #1 Reset = 1'b1;
        #1;
        chk("mid_rst_valid", {31'b0, Out_Valid}, 32'd0);
        chk("mid_rst_opcount", {16'b0, OpCount}, 32'd0);
        chk("mid_rst_resultop", {28'b0, ResultOp}, 32'hF);
        #1 Reset = 1'b0;
        exp_q.delete();
        s1_v = 1'b0;
        cnt = '0;
        ovr = 1'b0;
        step(4'hA, 8'hF0, 8'h3C, 3'b000, 1'b0, 1'b0);
        chk("post_rst_1edge", {31'b0, Out_Valid}, 32'd0);
        step(4'hF, 8'h00, 8'h00, 3'b100, 1'b0, 1'b0);
        chk("post_rst_valid", {31'b0, Out_Valid}, 32'd1);
        chk("post_rst_op", {28'b0, ResultOp}, 32'hA);
        chk("post_rst_result", {24'b0, Result}, 32'hCC);
        idle(1'b1, 3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
